counter_reader: RTL and testbench
=================================

Name: counter_reader

Overview:
- Downstream consumer of counter_mux in the PCIe transaction-layer statistics path.
- On a start pulse while the link is idle, walks idx through every FIFO counter (0..NUM_CNT-1) using the req/valid handshake.
- Captures each 8-bit count into a snapshot register and presents all counts as one packed word, with a done pulse.
- Provides a per-read timeout so a stalled mux cannot hang the scan.

Parameters:
- NUM_CNT, 5, number of counters scanned (idx 0..NUM_CNT-1); legal range 1..8.
- DW, 8, width of each count word.
- TIMEOUT, 15, maximum cycles spent waiting for valid per counter; legal range 1..255.

Ports:
- clk  input  1  single system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a scan.
- idle  input  1  link-idle indication; a scan may only begin while idle=1.
- data  input  DW  count value returned by counter_mux.
- valid  input  1  data qualifier from counter_mux.
- req  output  1  read request to counter_mux.
- idx  output  3  counter index presented to counter_mux.
- snapshot  output  NUM_CNT*DW  packed captured counts; counter k occupies bits [k*DW +: DW].
- done  output  1  one-cycle pulse when a scan completes.
- busy  output  1  high while a scan is in progress.
- timeout_err  output  1  sticky flag: at least one read in the last scan timed out.

Behaviour:
- Reset (reset=0, asynchronous): FSM enters S_IDLE. Outputs: req=0, idx=0, snapshot=0, done=0, busy=0, timeout_err=0. The wait counter clears to 0.
- States: S_IDLE, S_REQ, S_WAIT, S_DONE. The state register and all outputs are registered.
- S_IDLE:
  - If start=1 and idle=1, go to S_REQ. Set idx=0, busy=1, clear timeout_err.
  - If start=1 and idle=0, ignore start; no pending request is remembered.
- S_REQ: drive req=1 and clear the wait counter, then go to S_WAIT on the next cycle.
- S_WAIT:
  - req stays 1; idx is held stable.
  - If valid=1, write data into snapshot slot idx. Then:
    - if idx==NUM_CNT-1, go to S_DONE;
    - otherwise increment idx and return to S_REQ.
  - If valid=0, increment the wait counter. When it reaches TIMEOUT, write 0 into slot idx, set timeout_err=1, and advance exactly as in the valid case.
  - If valid=1 arrives in the same cycle the counter reaches TIMEOUT, valid wins: data is captured and no error is flagged.
- req drops to 0 for one cycle between consecutive counters (the S_REQ re-entry cycle has req=0 on the registered output). Each read therefore costs at least 2 cycles, and a full scan of 5 counters takes at least 10 cycles from start to done.
- S_DONE: done=1 for exactly one cycle, busy=0, req=0, idx=0. Go to S_IDLE.
- start while busy=1 is ignored.
- idle dropping mid-scan does not abort the scan; the scan runs to completion.
- Reset asserted mid-scan aborts immediately to reset values. The snapshot is cleared.
- Snapshot slots not yet rewritten in the current scan keep their previous-scan values until overwritten.
- idx never exceeds NUM_CNT-1; there is no wrap beyond the last counter.

Optional Feature:
- Macro: COUNTER_READER_SUM_EN.
- Defined: adds output port sum (width DW+3). sum is the sum of all snapshot slots and is registered, updating in the same cycle done pulses. It resets to 0.
- Undefined: the sum port and its adder are absent. All other behaviour is identical.

Test Plan:
- Basic scan: idle=1, start pulse; mux returns valid one cycle after each req with data 3,7,0,255,12 -> snapshot={12,255,0,7,3} (slot 4..0), done pulses once, timeout_err=0, busy high throughout the scan.
- Blocked start: idle=0 with a start pulse -> busy, req and done stay 0; a later start with idle=1 scans normally.
- Timeout: valid is never asserted for idx=2 -> after 15 wait cycles slot 2=0, timeout_err=1, scan continues to idx=4 and done pulses. The next successful scan clears timeout_err.
- Race at the limit: valid=1 with data 9 arrives exactly on wait cycle 15 for idx=1 -> slot 1=9, timeout_err=0.
- Reset mid-scan: reset=0 while in S_WAIT with idx=3 -> req=0, idx=0, busy=0, snapshot=0 immediately, without waiting for clk. A start after reset release gives a clean scan.
- COUNTER_READER_SUM_EN defined: counts 3,7,0,255,12 -> sum=277 in the done cycle. Extra start pulses while busy cause no restart.

Source files
------------

// File: rtl/counter_reader_if.sv
// counter_reader_if
// Read handshake between counter_reader (master) and counter_mux (slave).
//   req   : read request, driven by the reader
//   idx   : index of the counter being read, driven by the reader
//   data  : count value returned by the mux
//   valid : qualifies data, driven by the mux
interface counter_reader_if #(
  parameter int DW = 8
);
  logic          req;
  logic [2:0]    idx;
  logic [DW-1:0] data;
  logic          valid;

  modport master (
    output req,
    output idx,
    input  data,
    input  valid
  );

  modport slave (
    input  req,
    input  idx,
    output data,
    output valid
  );
endinterface

// File: rtl/counter_reader.sv
// counter_reader
// On a start pulse while the link is idle, reads every counter of counter_mux
// (idx 0..NUM_CNT-1) over the req/valid handshake, collects the counts into a
// packed snapshot and pulses done. A read that sees no valid within TIMEOUT
// wait cycles stores 0 and raises the sticky timeout_err for that scan.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-low reset
//   start       : one-cycle scan request (honoured only in idle state with idle=1)
//   idle        : link-idle indication
//   mux         : counter_reader_if.master (req, idx, data, valid)
//   snapshot    : captured counts, counter k at [k*DW +: DW]
//   done        : one-cycle pulse at end of scan
//   busy        : high while a scan is in progress
//   timeout_err : at least one read of the last scan timed out
//   sum         : (COUNTER_READER_SUM_EN only) sum of all snapshot slots
//
// Optional feature macro: COUNTER_READER_SUM_EN
//
// State   | meaning
// S_IDLE  | waiting for start while idle=1
// S_REQ   | one-cycle gap; arms req and clears the wait counter
// S_WAIT  | req high, waiting for valid or timeout on counter idx
// S_DONE  | done pulse cycle, returns to S_IDLE
module counter_reader #(
  parameter int NUM_CNT = 5,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  idle,
  counter_reader_if.master      mux,
  output logic [NUM_CNT*DW-1:0] snapshot,
  output logic                  done,
  output logic                  busy,
  output logic                  timeout_err
`ifdef COUNTER_READER_SUM_EN
  ,
  output logic [DW+2:0]         sum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] IDX_LAST = 3'(NUM_CNT - 1);
  // Counter value during the final allowed wait cycle; a miss here expires.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic [2:0]            idx_q, idx_d;
  logic [NUM_CNT*DW-1:0] snapshot_q, snapshot_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  hit, expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      req_q         <= 1'b0;
      idx_q         <= '0;
      snapshot_q    <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      idx_q         <= idx_d;
      snapshot_q    <= snapshot_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    idx_d         = idx_q;
    snapshot_d    = snapshot_q;
    done_d        = 1'b0;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;
    wait_cnt_d    = wait_cnt_q;
    hit           = 1'b0;
    expire        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && idle) begin
          state_d       = S_REQ;
          idx_d         = '0;
          busy_d        = 1'b1;
          timeout_err_d = 1'b0;
        end
      end
      S_REQ: begin
        req_d      = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // valid takes priority over an expiry in the same cycle
        hit    = mux.valid;
        expire = !mux.valid && (wait_cnt_q == WAIT_LAST);
        if (!mux.valid) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (hit || expire) begin
          snapshot_d[idx_q*DW +: DW] = hit ? mux.data : '0;
          if (expire) begin
            timeout_err_d = 1'b1;
          end
          req_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mux.req     = req_q;
  assign mux.idx     = idx_q;
  assign snapshot    = snapshot_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

`ifdef COUNTER_READER_SUM_EN
  logic [DW+2:0] sum_q, sum_d, sum_all;

  // Summing the next-state snapshot lets sum update on the same edge as done.
  always_comb begin
    sum_all = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      sum_all = sum_all + {3'b000, snapshot_d[k*DW +: DW]};
    end
    sum_d = sum_q;
    if (done_d) begin
      sum_d = sum_all;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;
`endif

endmodule

// File: tb/tb_counter_reader.sv
// Scoreboard bench for counter_reader: each scan pushes its hand-computed
// result; a monitor pops and compares whenever done pulses.
module tb_counter_reader;
  localparam int NUM_CNT = 5;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic                  clk   = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic                  idle  = 1'b1;
  logic [NUM_CNT*DW-1:0] snapshot;
  logic                  done;
  logic                  busy;
  logic                  timeout_err;
`ifdef COUNTER_READER_SUM_EN
  logic [DW+2:0]         sum;
`endif

  counter_reader_if #(.DW(DW)) mux_if ();

  counter_reader #(
    .NUM_CNT(NUM_CNT),
    .DW(DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .idle(idle),
    .mux(mux_if),
    .snapshot(snapshot),
    .done(done),
    .busy(busy),
    .timeout_err(timeout_err)
`ifdef COUNTER_READER_SUM_EN
    ,
    .sum(sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [39:0] snap;
    logic        err;
    int          sum;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] m_data[5];
  logic [7:0] m_delay[5];   // valid on this req-high cycle; 0 = never answer

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // counter_mux model: answers after m_delay[idx] cycles of req high
  initial begin
    int req_cnt;
    req_cnt = 0;
    mux_if.valid = 1'b0;
    mux_if.data  = 8'hEE;
    forever begin
      @(posedge clk);
      #1;
      if (mux_if.req) begin
        req_cnt++;
        if (m_delay[mux_if.idx] != 0 && req_cnt == int'(m_delay[mux_if.idx])) begin
          mux_if.valid = 1'b1;
          mux_if.data  = m_data[mux_if.idx];
        end else begin
          mux_if.valid = 1'b0;
          mux_if.data  = 8'hEE;
        end
      end else begin
        req_cnt      = 0;
        mux_if.valid = 1'b0;
        mux_if.data  = 8'hEE;
      end
    end
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: actual=done required=no_done");
        end else begin
          n_checks--;
          e = sb_q.pop_front();
          check({e.name, "_snapshot"}, 64'(snapshot), 64'(e.snap));
          check({e.name, "_timeout_err"}, 64'(timeout_err), 64'(e.err));
`ifdef COUNTER_READER_SUM_EN
          check({e.name, "_sum"}, 64'(sum), 64'(e.sum));
`endif
        end
      end
    end
  end

  task automatic load_vec(input logic [39:0] dvec, input logic [39:0] lvec);
    for (int k = 0; k < 5; k++) begin
      m_data[k]  = dvec[k*8 +: 8];
      m_delay[k] = lvec[k*8 +: 8];
    end
  endtask

  task automatic run_scan(input string name, input logic [39:0] dvec, input logic [39:0] lvec,
                          input logic [39:0] exp_snap, input logic exp_err, input int exp_sum,
                          input int exp_lat, input bit extra_start, input bit drop_idle);
    exp_t e;
    int   lat;
    bit   busy_low;
    @(negedge clk);
    load_vec(dvec, lvec);
    e.name = name;
    e.snap = exp_snap;
    e.err  = exp_err;
    e.sum  = exp_sum;
    sb_q.push_back(e);
    idle     = 1'b1;
    start    = 1'b1;
    lat      = -1;
    busy_low = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (extra_start && (cyc == 3 || cyc == 6)) start = 1'b1;
      if (drop_idle && cyc == 2) idle = 1'b0;
      if (done) begin
        lat = cyc - 1;
        break;
      end
      if (!busy) busy_low = 1'b1;
    end
    start = 1'b0;
    idle  = 1'b1;
    check({name, "_done_seen"}, 64'(lat >= 0), 64'(1));
    check({name, "_busy_held"}, 64'(busy_low), 64'(0));
    if (exp_lat >= 0) check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit found;
    load_vec(40'h0, 40'h0);
    #2;
    check("rst_req", 64'(mux_if.req), 64'(0));
    check("rst_idx", 64'(mux_if.idx), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_timeout_err", 64'(timeout_err), 64'(0));
    check("rst_snapshot", 64'(snapshot), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // basic scan, valid on second req cycle, extra starts while busy
    run_scan("basic", 40'h0C_FF_00_07_03, 40'h02_02_02_02_02,
             40'h0C_FF_00_07_03, 1'b0, 277, -1, 1'b1, 1'b0);

    // blocked start
    @(negedge clk);
    idle  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("blocked_busy", 64'(busy), 64'(0));
    check("blocked_req", 64'(mux_if.req), 64'(0));
    check("blocked_done", 64'(done), 64'(0));
    idle = 1'b1;

    // fastest scan: 2 cycles per counter, idle drops mid-scan
    run_scan("fast", 40'h32_28_1E_14_0A, 40'h01_01_01_01_01,
             40'h32_28_1E_14_0A, 1'b0, 150, 10, 1'b0, 1'b1);

    // counter 2 never answers
    run_scan("timeout", 40'h05_04_03_02_01, 40'h01_01_00_01_01,
             40'h05_04_00_02_01, 1'b1, 12, -1, 1'b0, 1'b0);

    // a clean scan clears timeout_err
    run_scan("recover", 40'h32_28_1E_14_0A, 40'h01_01_01_01_01,
             40'h32_28_1E_14_0A, 1'b0, 150, 10, 1'b0, 1'b0);

    // valid on the last allowed wait cycle wins
    run_scan("race", 40'h04_03_02_09_01, 40'h01_01_01_0F_01,
             40'h04_03_02_09_01, 1'b0, 19, -1, 1'b0, 1'b0);

    // valid one cycle too late
    run_scan("late", 40'h05_06_07_09_08, 40'h01_01_01_10_01,
             40'h05_06_07_00_08, 1'b1, 26, -1, 1'b0, 1'b0);

    // reset while waiting on idx 3
    @(negedge clk);
    load_vec(40'h05_04_03_02_01, 40'h01_0A_01_01_01);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk);
      #1;
      if (mux_if.req && mux_if.idx == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_reach_idx3", 64'(found), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    check("midrst_req", 64'(mux_if.req), 64'(0));
    check("midrst_idx", 64'(mux_if.idx), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_snapshot", 64'(snapshot), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_scan("post_reset", 40'h0C_FF_00_07_03, 40'h02_02_02_02_02,
             40'h0C_FF_00_07_03, 1'b0, 277, -1, 1'b0, 1'b0);

    repeat (20) @(negedge clk);
    check("pending_scans", 64'(sb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
